// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit path.
// Output-mux select codes are also used by the mux block.
package uart_tx_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_STOP_2 = 3'd5;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_STOP  = 2'b01;
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational frame parity: even when par_typ=0, odd when 1.
module parity_calc #(
   parameter int IN_WIDTH = 8
) (
   input  logic [IN_WIDTH-1:0] p_data,
   input  logic                par_typ,
   output logic                par
);

   assign par = (^p_data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data, optional parity, 1-2 stops.
// Drives serializer enable and the output mux select.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int IN_WIDTH = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [IN_WIDTH-1:0] P_DATA,
   input  logic                DATA_VALID,
   input  logic                PAR_EN,
   input  logic                PAR_TYP,
   input  logic                STOP2,
   input  logic                ser_done,
   output logic                ser_en,
   output logic                BUSY,
   output logic [1:0]          mux_sel,
   output logic                par_bit,
   output logic                seq_err
);

   localparam int CW = $clog2(IN_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic          par_en_q, par_en_d;
   logic          stop2_q, stop2_d;
   logic          par_bit_q, par_bit_d;
   logic          seq_err_q, seq_err_d;
   logic          busy_q, busy_d;
   logic          par_calc;

   parity_calc #(.IN_WIDTH(IN_WIDTH)) u_par (
      .p_data  (P_DATA),
      .par_typ (PAR_TYP),
      .par     (par_calc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         par_en_q  <= 1'b0;
         stop2_q   <= 1'b0;
         par_bit_q <= 1'b0;
         seq_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         par_en_q  <= par_en_d;
         stop2_q   <= stop2_d;
         par_bit_q <= par_bit_d;
         seq_err_q <= seq_err_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      par_en_d  = par_en_q;
      stop2_d   = stop2_q;
      par_bit_d = par_bit_q;
      seq_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (DATA_VALID) begin
               state_d   = S_START;
               par_en_d  = PAR_EN;
               stop2_d   = STOP2;
               par_bit_d = par_calc;
            end
         end
         S_START: begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
         end
         S_DATA: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST) begin
               // Missing done still exits so the line never stalls.
               seq_err_d = ~ser_done;
               state_d   = par_en_q ? S_PARITY : S_STOP;
            end else begin
               seq_err_d = ser_done;
            end
         end
         S_PARITY: state_d = S_STOP;
         S_STOP:   state_d = stop2_q ? S_STOP_2 : S_IDLE;
         S_STOP_2: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_comb begin
      ser_en  = 1'b0;
      mux_sel = MUX_STOP;
      case (state_q)
         S_START: begin
            ser_en  = 1'b1;
            mux_sel = MUX_START;
         end
         S_DATA: begin
            ser_en  = (bit_cnt_q != LAST);
            mux_sel = MUX_DATA;
         end
         S_PARITY: mux_sel = MUX_PAR;
         default:  mux_sel = MUX_STOP;
      endcase
   end

   assign BUSY    = busy_q;
   assign par_bit = par_bit_q;
   assign seq_err = seq_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a frame-level model.
// Directed scenarios followed by randomized frames.
module tb_uart_tx_ctrl;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [W-1:0] P_DATA = '0;
   logic         DATA_VALID = 1'b0;
   logic         PAR_EN = 1'b0;
   logic         PAR_TYP = 1'b0;
   logic         STOP2 = 1'b0;
   logic         ser_done = 1'b0;
   logic         ser_en;
   logic         BUSY;
   logic [1:0]   mux_sel;
   logic         par_bit;
   logic         seq_err;

   int errors = 0;
   int checks = 0;

   uart_tx_ctrl #(.IN_WIDTH(W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .ser_done   (ser_done),
      .ser_en     (ser_en),
      .BUSY       (BUSY),
      .mux_sel    (mux_sel),
      .par_bit    (par_bit),
      .seq_err    (seq_err)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, {7'd0, BUSY}, 8'd0);
      chk({tag, "_mux"}, {6'd0, mux_sel}, 8'd1);
      chk({tag, "_sen"}, {7'd0, ser_en}, 8'd0);
   endtask

   // One frame from the request cycle; indices are data-bit numbers, -1 = off.
   task automatic run_frame(input logic [W-1:0] d, input logic pe,
                            input logic pt, input logic s2,
                            input bit hold, input bit drop,
                            input int early, input int pulse,
                            input int rst_at);
      logic [1:0] q[$];
      int   len;
      int   di;
      logic exp_par;
      logic err_prev;
      logic offend;
      len = 2 + W + int'(pe) + int'(s2);
      q.push_back(2'b00);
      for (int k = 0; k < W; k++) q.push_back(2'b10);
      if (pe) q.push_back(2'b11);
      q.push_back(2'b01);
      if (s2) q.push_back(2'b01);
      exp_par = 1'b0;
      for (int k = 0; k < W; k++) exp_par = exp_par ^ d[k];
      exp_par = exp_par ^ pt;
      err_prev = 1'b0;

      chk_idle("req");
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
      DATA_VALID = 1'b1;
      tick();
      for (int i = 0; i < len; i++) begin
         di = i - 1;
         ser_done = ((di == W - 1) && !drop) ||
                    ((early >= 0) && (di == early));
         offend = 1'b0;
         if (di >= 0 && di < W)
            offend = (di == W - 1) ? !ser_done : ser_done;
         if (pulse >= 0 && di == pulse) begin
            DATA_VALID = 1'b1;
            P_DATA = ~d;
            PAR_TYP = ~pt;
         end else if (!hold) begin
            DATA_VALID = 1'b0;
         end
         chk($sformatf("mux_c%0d", i), {6'd0, mux_sel}, {6'd0, q[i]});
         chk($sformatf("sen_c%0d", i), {7'd0, ser_en},
             {7'd0, (i < W) ? 1'b1 : 1'b0});
         chk($sformatf("busy_c%0d", i), {7'd0, BUSY}, 8'd1);
         chk($sformatf("par_c%0d", i), {7'd0, par_bit}, {7'd0, exp_par});
         chk($sformatf("serr_c%0d", i), {7'd0, seq_err}, {7'd0, err_prev});
         if (rst_at >= 0 && di == rst_at) begin
            RST = 1'b1;
            tick();
            RST = 1'b0;
            ser_done = 1'b0;
            DATA_VALID = 1'b0;
            chk_idle("rst_mid");
            chk("rst_mid_par", {7'd0, par_bit}, 8'd0);
            chk("rst_mid_serr", {7'd0, seq_err}, 8'd0);
            return;
         end
         err_prev = offend;
         tick();
      end
      ser_done = 1'b0;
      chk_idle("post");
      chk("post_serr", {7'd0, seq_err}, {7'd0, err_prev});
      chk("post_par", {7'd0, par_bit}, {7'd0, exp_par});
   endtask

   initial begin
      RST = 1'b1;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_par", {7'd0, par_bit}, 8'd0);
      chk("reset_serr", {7'd0, seq_err}, 8'd0);
      RST = 1'b0;
      tick();
      chk_idle("after_reset");

      run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 0, -1, -1, -1);
      tick();
      run_frame(8'h01, 1'b1, 1'b1, 1'b1, 0, 0, -1, -1, -1);
      tick();
      // Held request restarts straight out of the single IDLE cycle.
      run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1, 0, -1, -1, -1);
      run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1, -1);
      tick();
      run_frame(8'h3C, 1'b1, 1'b1, 1'b0, 0, 0, -1, 2, -1);
      tick();
      run_frame(8'h96, 1'b1, 1'b0, 1'b0, 0, 1, -1, -1, -1);
      tick();
      run_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0, 0, 4, -1, -1);
      tick();
      run_frame(8'hC3, 1'b1, 1'b0, 1'b1, 0, 0, -1, -1, 3);
      run_frame(8'h7E, 1'b1, 1'b1, 1'b0, 0, 0, -1, -1, -1);
      tick();

      for (int n = 0; n < 8; n++) begin
         logic [W-1:0] rd;
         logic rpe, rpt, rs2;
         rd  = W'($urandom);
         rpe = 1'($urandom_range(0, 1));
         rpt = 1'($urandom_range(0, 1));
         rs2 = 1'($urandom_range(0, 1));
         run_frame(rd, rpe, rpt, rs2, 0, 0, -1, -1, -1);
         tick();
      end

      chk_idle("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
